// File: rtl/fifo_lvl.sv
// fifo_lvl: parametrised synchronous FIFO for the chargen datapath.
// Active-low strobes and flags. It holds a full DEPTH entries by giving each
// pointer one extra wrap bit. It exports the fill level, the almost-full and
// almost-empty flags, and sticky overflow/underflow flags.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through output.
// When the macro is undefined, the read is registered with one cycle of latency.
module fifo_lvl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             n_clr,
    input  logic [WIDTH-1:0] port_in,
    input  logic             n_wr,
    output logic [WIDTH-1:0] port_out,
    input  logic             n_rd,
    output logic             n_empty,
    output logic             n_full,
    output logic             n_afull,
    output logic             n_aempty,
    output logic [AW:0]      level,
    output logic             n_ovf,
    output logic             n_udf
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] LVL_AE   = (AW + 1)'(AE_LEVEL);

    logic [WIDTH-1:0] buff [DEPTH];
    logic [AW:0]      rp;
    logic [AW:0]      wp;
    logic             is_empty;
    logic             is_full;
    logic             rd_ok;
    logic             wr_ok;

    // Level and flags decode combinationally from the registered pointers.
    // A write into a full FIFO is still accepted when a read frees the head slot
    // in the same cycle.
    always_comb begin
        level    = wp - rp;
        is_empty = (level == '0);
        is_full  = (level == LVL_FULL);
        n_empty  = ~is_empty;
        n_full   = ~is_full;
        n_afull  = ~(level >= LVL_AF);
        n_aempty = ~(level <= LVL_AE);
        rd_ok    = ~n_rd & ~is_empty;
        wr_ok    = ~n_wr & (~is_full | rd_ok);
    end

    // Pointer registers. The synchronous clear takes priority over both strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rp <= '0;
            wp <= '0;
        end else if (!n_clr) begin
            rp <= '0;
            wp <= '0;
        end else begin
            if (rd_ok) rp <= rp + 1'b1;
            if (wr_ok) wp <= wp + 1'b1;
        end
    end

    // Sticky error flags. Once a flag drops low, only a clear or a reset raises it again.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            n_ovf <= 1'b1;
            n_udf <= 1'b1;
        end else if (!n_clr) begin
            n_ovf <= 1'b1;
            n_udf <= 1'b1;
        end else begin
            if (!n_wr && !wr_ok) n_ovf <= 1'b0;
            if (!n_rd && is_empty) n_udf <= 1'b0;
        end
    end

    // Storage array, not reset. When full with a read and a write in the same
    // cycle, the head word is read out before it is overwritten.
    always_ff @(posedge clk) begin
        if (n_clr && wr_ok) buff[wp[AW-1:0]] <= port_in;
    end

`ifdef FIFO_FWFT_EN
    // Fall-through: the head word is shown directly. A read strobe only pops it.
    always_comb begin
        port_out = '0;
        if (!is_empty) port_out = buff[rp[AW-1:0]];
    end
`else
    // Registered read. The output holds its value across a clear and a rejected read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            port_out <= '0;
        end else if (n_clr && rd_ok) begin
            port_out <= buff[rp[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: directed and randomized bench for fifo_lvl.
// The reference model is a queue of words with the fill and flag rules
// computed arithmetically.
module tb_fifo_lvl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AF    = 2;
    localparam int AE    = 1;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             n_clr;
    logic [WIDTH-1:0] port_in;
    logic             n_wr;
    logic [WIDTH-1:0] port_out;
    logic             n_rd;
    logic             n_empty;
    logic             n_full;
    logic             n_afull;
    logic             n_aempty;
    logic [AW:0]      level;
    logic             n_ovf;
    logic             n_udf;

    fifo_lvl #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .n_clr   (n_clr),
        .port_in (port_in),
        .n_wr    (n_wr),
        .port_out(port_out),
        .n_rd    (n_rd),
        .n_empty (n_empty),
        .n_full  (n_full),
        .n_afull (n_afull),
        .n_aempty(n_aempty),
        .level   (level),
        .n_ovf   (n_ovf),
        .n_udf   (n_udf)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_out;
    logic             m_ovf;
    logic             m_udf;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        logic [WIDTH-1:0] exp_out;
        sz = q.size();
`ifdef FIFO_FWFT_EN
        exp_out = (sz > 0) ? q[0] : '0;
`else
        exp_out = m_out;
`endif
        check({tag, "/level"}, 32'(level), 32'(sz));
        check({tag, "/n_empty"}, 32'(n_empty), 32'(sz != 0));
        check({tag, "/n_full"}, 32'(n_full), 32'(sz != DEPTH));
        check({tag, "/n_afull"}, 32'(n_afull), 32'(!(sz >= AF)));
        check({tag, "/n_aempty"}, 32'(n_aempty), 32'(!(sz <= AE)));
        check({tag, "/n_ovf"}, 32'(n_ovf), 32'(m_ovf));
        check({tag, "/n_udf"}, 32'(n_udf), 32'(m_udf));
        check({tag, "/port_out"}, 32'(port_out), 32'(exp_out));
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0;
        m_ovf = 1'b1;
        m_udf = 1'b1;
    endtask

    // Apply one cycle of strobes. Update the model at the edge, then check 1 time unit later.
    task automatic step(input string tag, input logic wr, input logic rd, input logic clr,
                        input logic [WIDTH-1:0] d);
        int sz;
        bit rd_ok;
        bit wr_ok;
        n_wr    = wr;
        n_rd    = rd;
        n_clr   = clr;
        port_in = d;
        @(posedge clk);
        sz    = q.size();
        rd_ok = !rd && sz > 0;
        wr_ok = !wr && (sz < DEPTH || rd_ok);
        if (!clr) begin
            q.delete();
            m_ovf = 1'b1;
            m_udf = 1'b1;
        end else begin
            if (!wr && !wr_ok) m_ovf = 1'b0;
            if (!rd && sz == 0) m_udf = 1'b0;
            if (rd_ok) m_out = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic wr1(input string tag, input logic [WIDTH-1:0] d);
        step(tag, 1'b0, 1'b1, 1'b1, d);
    endtask

    task automatic rd1(input string tag);
        step(tag, 1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic clr1(input string tag);
        step(tag, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        string wrap_chars;
        logic [WIDTH-1:0] b;
        n_rst   = 1'b0;
        n_clr   = 1'b1;
        n_wr    = 1'b1;
        n_rd    = 1'b1;
        port_in = '0;
        model_reset();
        #12;
        check_all("reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, then try one more write, which overflows.
        wr1("fill_a", "a");
        wr1("fill_b", "b");
        wr1("fill_c", "c");
        wr1("fill_d", "d");
        wr1("fill_ovf", "e");

        // Drain, then read once more while empty, which underflows.
        rd1("drain_a");
        rd1("drain_b");
        rd1("drain_c");
        rd1("drain_d");
        rd1("drain_udf");

        // Simultaneous read and write while full.
        clr1("clr0");
        wr1("sf_a", "a");
        wr1("sf_b", "b");
        wr1("sf_c", "c");
        wr1("sf_d", "d");
        step("sf_both", 1'b0, 1'b0, 1'b1, "e");
        for (int i = 0; i < 4; i++) rd1("sf_drain");

        // Simultaneous read and write while empty: the read is rejected.
        step("se_both", 1'b0, 1'b0, 1'b1, "z");
        rd1("se_drain");
        clr1("clr1");

        // Alternating single writes and reads so the pointers wrap several times.
        wrap_chars = "0123456789AB";
        for (int i = 0; i < 12; i++) begin
            b = wrap_chars[i];
            wr1("wrap_w", b);
            rd1("wrap_r");
        end

        // Clear at level 3 with overflow set. The write in the same cycle is discarded.
        for (int i = 0; i < 5; i++) wr1("cl_fill", 8'(8'h30 + i));
        rd1("cl_rd");
        step("cl_clr", 1'b0, 1'b1, 1'b0, "X");
        wr1("cl_w", "N");
        rd1("cl_r");

        // Asynchronous reset asserted mid-cycle takes effect immediately.
        wr1("ar_w0", 8'h11);
        wr1("ar_w1", 8'h22);
        rd1("ar_r");
        #3;
        n_rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        n_rst = 1'b1;

        // Randomized phases: write-biased, then read-biased, then balanced.
        for (int i = 0; i < 600; i++) begin
            int pw;
            int pr;
            logic wr;
            logic rd;
            logic clr;
            pw  = (i < 200) ? 75 : (i < 400) ? 25 : 50;
            pr  = (i < 200) ? 25 : (i < 400) ? 75 : 50;
            wr  = ($urandom_range(0, 99) < pw) ? 1'b0 : 1'b1;
            rd  = ($urandom_range(0, 99) < pr) ? 1'b0 : 1'b1;
            clr = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            step("rand", wr, rd, clr, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised synchronous FIFO and next-generation buffer for the chargen datapath.
- Uses the same active-low strobe/flag style as the existing byte FIFO.
- Holds a full DEPTH entries (pointer extra-bit scheme), exports fill level and almost-full/almost-empty flags.
- Sticky overflow/underflow error flags and a synchronous clear.
- Sits between the character generator and the output/serialiser stage.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 2
WIDTH, 8, data word width in bits
AF_LEVEL, DEPTH-2, n_afull asserts when level >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, n_aempty asserts when level <= AE_LEVEL (0..DEPTH-1)
AW, $clog2(DEPTH), derived pointer width; not to be overridden

Ports:
clk  in  1  clock, all state on rising edge
n_rst  in  1  reset, asynchronous, active-low
n_clr  in  1  synchronous clear, active-low
port_in  in  WIDTH  write data
n_wr  in  1  write strobe, active-low, one word per cycle held low
port_out  out  WIDTH  read data, registered
n_rd  in  1  read strobe, active-low, one word per cycle held low
n_empty  out  1  low when level == 0
n_full  out  1  low when level == DEPTH
n_afull  out  1  low when level >= AF_LEVEL
n_aempty  out  1  low when level <= AE_LEVEL
level  out  AW+1  current word count, 0..DEPTH
n_ovf  out  1  sticky overflow, low after a rejected write
n_udf  out  1  sticky underflow, low after a rejected read

Behaviour:
- Reset (n_rst low, async): rp = wp = 0, level = 0, port_out = 0, n_ovf = n_udf = 1. Flags follow: n_empty = 0, n_full = 1, n_aempty = 0, n_afull = 1 (unless AF_LEVEL == 0, which is disallowed).
- Pointers: rp and wp are AW+1 bits wide and wrap modulo 2*DEPTH. Memory is indexed by the low AW bits. level = wp - rp, truncated to AW+1 bits.
- All flags decode combinationally from registered pointers/level. No flag is itself a flop except n_ovf and n_udf.
- Write accepted when n_wr = 0 and (level < DEPTH, or a read is accepted in the same cycle): buff[wp] <= port_in, wp++.
- Read accepted when n_rd = 0 and level > 0: port_out <= buff[rp], rp++. Data appears one cycle after the strobe edge. port_out holds its value otherwise.
- Simultaneous rd+wr:
  - full: both accepted; level stays DEPTH; head word goes out before being overwritten.
  - empty: write accepted, read rejected (n_udf set); level becomes 1.
  - otherwise: both accepted, level unchanged.
- Overflow: n_wr = 0 while full with no accepted read -> word dropped, n_ovf <= 0. Stays low until n_clr or n_rst.
- Underflow: n_rd = 0 while empty -> n_udf <= 0. port_out unchanged, rp unchanged.
- n_clr = 0: rp = wp = 0, n_ovf = n_udf = 1 at next edge. port_out is not cleared. n_clr has priority over n_wr/n_rd in the same cycle.
- Memory contents are not reset. Only pointers, flags and port_out are.
- No state machine beyond pointer/flag registers. All updates single-cycle, no throughput bubbles.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through.
  - port_out = buff[rp] combinationally while level > 0, and 0 while empty.
  - n_rd = 0 acknowledges/pops the displayed word; no read latency.
  - Overflow/underflow, level and flag rules unchanged.
- Undefined: registered read as described above, one-cycle latency.

Test Plan:
- Reset: pulse n_rst low mid-cycle -> immediately level = 0, n_empty = 0, n_full = 1, n_aempty = 0, n_afull = 1, n_ovf = n_udf = 1, port_out = 0.
- Fill (DEPTH = 4, AF_LEVEL = 2, AE_LEVEL = 1): write "a","b","c","d" -> level 1..4. n_aempty goes 1 at level 2, n_afull goes 0 at level 2, n_full goes 0 at level 4. 5th write "e" -> level stays 4, n_ovf = 0.
- Drain: 4 reads -> port_out = 'a','b','c','d', each one cycle after its strobe; n_empty = 0 after last. 5th read -> port_out stays 'd', n_udf = 0.
- Simultaneous when full: full with "a".."d", one cycle n_wr = n_rd = 0 with "e" -> port_out = 'a', level = 4, n_ovf = 1. Drain yields 'b','c','d','e'.
- Wrap: 12 alternating single writes/reads of "0".."9","A","B" -> output order identical, level toggles 1/0, no flags set. Repeat with FIFO_FWFT_EN defined -> port_out shows each word the cycle after its write.
- Clear: with level 3 and n_ovf = 0, assert n_clr together with n_wr = 0 -> next cycle level = 0, n_ovf = 1, write discarded; the following write/read returns the new word.
